// File: rtl/small_first_one.sv
// Isolates the lowest set bit of a vector as a one-hot word (all zero when the input is zero).
module small_first_one #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] first_one
);

    // Two's-complement trick: x & -x keeps only the least significant set bit.
    assign first_one = data_in & (~data_in + WIDTH'(1));

endmodule

// File: rtl/set_bit_iterator.sv
// Accepts a vector, then emits one beat per set bit in ascending order
// over a valid/ready stream, flagging the highest set bit as last.
module set_bit_iterator #(
    parameter  int WIDTH       = 8,
    localparam int INDEX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       input_data,
    input  logic                   input_valid,
    output logic                   input_ready,
    output logic [WIDTH-1:0]       output_one_hot,
    output logic [INDEX_WIDTH-1:0] output_index,
    output logic                   output_last,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic                   busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       remaining_q, remaining_d;
    logic [WIDTH-1:0]       lowest;
    logic [INDEX_WIDTH-1:0] lowest_index;
    logic                   scan;
    logic                   is_last;

    small_first_one #(.WIDTH(WIDTH)) u_first_one (
        .data_in   (remaining_q),
        .first_one (lowest)
    );

    // One-hot to binary: OR together the positions of every set bit (only one is set).
    always_comb begin
        lowest_index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lowest[i]) lowest_index = lowest_index | INDEX_WIDTH'(i);
        end
    end

    assign scan    = (state_q == SCAN);
    assign is_last = ((remaining_q & ~lowest) == '0);

    assign input_ready    = ~scan;
    assign output_valid   = scan;
    assign busy           = scan;
    assign output_one_hot = scan ? lowest : '0;
    assign output_index   = scan ? lowest_index : '0;
    assign output_last    = scan & is_last;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                // All-zero vectors are consumed without producing beats.
                if (input_valid && (input_data != '0)) begin
                    remaining_d = input_data;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (output_ready) begin
                    remaining_d = remaining_q & ~lowest;
                    if (is_last) state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_set_bit_iterator.sv
// Randomized self-checking bench for set_bit_iterator against a queue-based set-bit model.
module tb_set_bit_iterator;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] input_data;
    logic       input_valid;
    logic       input_ready;
    logic [7:0] output_one_hot;
    logic [2:0] output_index;
    logic       output_last;
    logic       output_valid;
    logic       output_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    set_bit_iterator #(.WIDTH(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .input_data     (input_data),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
        .output_one_hot (output_one_hot),
        .output_index   (output_index),
        .output_last    (output_last),
        .output_valid   (output_valid),
        .output_ready   (output_ready),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Reference: list of set-bit positions in ascending order.
    function automatic void model_bits(input logic [7:0] v, output int q[$]);
        q = {};
        for (int b = 0; b < 8; b++) if (v[b]) q.push_back(b);
    endfunction

    task automatic test_reset();
        reset = 1'b1; input_valid = 1'b0; input_data = '0; output_ready = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (input_ready !== 1'b1 || output_valid !== 1'b0 || busy !== 1'b0 ||
            output_one_hot !== 8'h00 || output_index !== 3'd0 || output_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: rdy=%b vld=%b busy=%b oh=%h idx=%0d last=%b required 1 0 0 00 0 0",
                     input_ready, output_valid, busy, output_one_hot, output_index, output_last);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (input_ready !== 1'b1 || output_valid !== 1'b0 || busy !== 1'b0 ||
            output_one_hot !== 8'h00 || output_index !== 3'd0 || output_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b busy=%b oh=%h idx=%0d last=%b required 1 0 0 00 0 0",
                     input_ready, output_valid, busy, output_one_hot, output_index, output_last);
        end
    endtask

    task automatic test_pattern_a4();
        int q[$];
        logic [7:0] oh;
        model_bits(8'hA4, q);
        output_ready = 1'b1;
        input_data = 8'hA4; input_valid = 1'b1;
        @(posedge clock); @(negedge clock);
        input_valid = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            oh = 8'h01 << q[k];
            checks++;
            if (output_valid !== 1'b1 || output_index !== 3'(q[k]) || output_one_hot !== oh ||
                output_last !== (k == q.size() - 1) || busy !== 1'b1 || input_ready !== 1'b0) begin
                errors++;
                $display("FAIL a4_beat%0d: vld=%b idx=%0d oh=%h last=%b busy=%b rdy=%b required 1 %0d %h %b 1 0",
                         k, output_valid, output_index, output_one_hot, output_last, busy, input_ready,
                         q[k], oh, k == q.size() - 1);
            end
            @(negedge clock);
        end
        checks++;
        if (input_ready !== 1'b1 || output_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL a4_done: rdy=%b vld=%b busy=%b required 1 0 0", input_ready, output_valid, busy);
        end
    endtask

    task automatic test_zero();
        output_ready = 1'b1;
        input_data = 8'h00; input_valid = 1'b1;
        @(posedge clock); @(negedge clock);
        input_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (output_valid !== 1'b0 || input_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_vec c%0d: vld=%b rdy=%b busy=%b required 0 1 0",
                         c, output_valid, input_ready, busy);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_ff_stall();
        int q[$];
        int k = 0;
        int cyc = 0;
        logic       stalled = 1'b0;
        logic [7:0] p_oh;
        logic [2:0] p_idx;
        logic       p_last;
        logic [7:0] oh;
        model_bits(8'hFF, q);
        input_data = 8'hFF; input_valid = 1'b1; output_ready = 1'b0;
        @(posedge clock); @(negedge clock);
        input_valid = 1'b0;
        while (k < q.size() && cyc < 200) begin
            if (stalled) begin
                checks++;
                if (output_one_hot !== p_oh || output_index !== p_idx || output_last !== p_last ||
                    output_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL ff_hold: oh=%h idx=%0d last=%b vld=%b required %h %0d %b 1",
                             output_one_hot, output_index, output_last, output_valid, p_oh, p_idx, p_last);
                end
            end
            oh = 8'h01 << q[k];
            checks++;
            if (output_valid !== 1'b1 || output_index !== 3'(q[k]) || output_one_hot !== oh ||
                output_last !== (k == q.size() - 1)) begin
                errors++;
                $display("FAIL ff_beat%0d: vld=%b idx=%0d oh=%h last=%b required 1 %0d %h %b",
                         k, output_valid, output_index, output_one_hot, output_last, q[k], oh, k == q.size() - 1);
            end
            output_ready = 1'($urandom_range(0, 1));
            stalled = ~output_ready;
            p_oh = output_one_hot; p_idx = output_index; p_last = output_last;
            @(posedge clock);
            if (output_ready) k++;
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (k != q.size() || output_valid !== 1'b0 || input_ready !== 1'b1) begin
            errors++;
            $display("FAIL ff_done: beats=%0d vld=%b rdy=%b required %0d 0 1", k, output_valid, input_ready, q.size());
        end
    endtask

    task automatic test_reset_abort();
        output_ready = 1'b1;
        input_data = 8'hFF; input_valid = 1'b1;
        @(posedge clock); @(negedge clock);
        input_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (output_valid !== 1'b1 || output_index !== 3'd2) begin
            errors++;
            $display("FAIL abort_pre: vld=%b idx=%0d required 1 2", output_valid, output_index);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (output_valid !== 1'b0 || busy !== 1'b0 || input_ready !== 1'b1 || output_one_hot !== 8'h00) begin
            errors++;
            $display("FAIL abort_async: vld=%b busy=%b rdy=%b oh=%h required 0 0 1 00",
                     output_valid, busy, input_ready, output_one_hot);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        input_data = 8'h80; input_valid = 1'b1;
        @(posedge clock); @(negedge clock);
        input_valid = 1'b0;
        checks++;
        if (output_valid !== 1'b1 || output_index !== 3'd7 || output_one_hot !== 8'h80 || output_last !== 1'b1) begin
            errors++;
            $display("FAIL abort_next: vld=%b idx=%0d oh=%h last=%b required 1 7 80 1",
                     output_valid, output_index, output_one_hot, output_last);
        end
        @(negedge clock);
        checks++;
        if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_done: vld=%b rdy=%b required 0 1", output_valid, input_ready);
        end
    endtask

    task automatic test_sweep();
        int q[$];
        int k;
        int cyc;
        int bad;
        logic [7:0] v;
        logic [7:0] oh;
        for (int n = 0; n < 256; n++) begin
            v = 8'(n);
            model_bits(v, q);
            bad = 0;
            checks++;
            if (input_ready !== 1'b1) begin
                bad++;
                $display("FAIL sweep_ready v=%h: rdy=%b required 1", v, input_ready);
            end
            input_data = v; input_valid = 1'b1;
            @(posedge clock); @(negedge clock);
            input_valid = 1'b0;
            k = 0; cyc = 0;
            while (k < q.size() && cyc < 100) begin
                oh = 8'h01 << q[k];
                if (output_valid !== 1'b1 || output_index !== 3'(q[k]) || output_one_hot !== oh ||
                    output_last !== (k == q.size() - 1)) begin
                    bad++;
                    $display("FAIL sweep_beat v=%h k=%0d: vld=%b idx=%0d oh=%h last=%b required 1 %0d %h %b",
                             v, k, output_valid, output_index, output_one_hot, output_last,
                             q[k], oh, k == q.size() - 1);
                end
                output_ready = 1'($urandom_range(0, 1));
                @(posedge clock);
                if (output_ready) k++;
                @(negedge clock);
                cyc++;
            end
            if (k != q.size() || output_valid !== 1'b0) begin
                bad++;
                $display("FAIL sweep_count v=%h: beats=%0d vld=%b required %0d 0", v, k, output_valid, q.size());
            end
            if (bad != 0) errors++;
        end
    endtask

    initial begin
        test_reset();
        test_pattern_a4();
        test_zero();
        test_ff_stall();
        test_reset_abort();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/set_bit_iterator.md
SET_BIT_ITERATOR -- requirements
Module: set_bit_iterator

Interface
REQ-001 Parameter: WIDTH, default 8, width of the scanned data vector; SHALL be at least 1.
REQ-002 Parameter: INDEX_WIDTH, default max(1, clog2(WIDTH)), derived, width of the binary index output; SHALL NOT be overridden.
REQ-003 Port: clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous and active-high.
REQ-005 Port: input_data  input  WIDTH  vector to scan.
REQ-006 Port: input_valid  input  1  input_data is valid.
REQ-007 Port: input_ready  output  1  block accepts a vector this cycle.
REQ-008 Port: output_one_hot  output  WIDTH  one-hot position of the current set bit.
REQ-009 Port: output_index  output  INDEX_WIDTH  binary index of the current set bit.
REQ-010 Port: output_last  output  1  current beat is the highest set bit of the vector.
REQ-011 Port: output_valid  output  1  output beat is valid.
REQ-012 Port: output_ready  input  1  consumer accepts the beat.
REQ-013 Port: busy  output  1  high while a vector is being iterated.

Function
REQ-014 The block SHALL have two states: IDLE and SCAN.
REQ-015 In IDLE, input_ready SHALL be 1, output_valid 0, busy 0.
REQ-016 In SCAN, input_ready SHALL be 0, output_valid 1, busy 1.
REQ-017 An input handshake (input_valid and input_ready at a rising edge) with nonzero data SHALL load the remaining-bits register and enter SCAN.
REQ-018 An input handshake with all-zero data SHALL be consumed, produce no output beat, and remain in IDLE.
REQ-019 Latency: a vector accepted at edge N SHALL present its first beat from edge N onward, visible in cycle N+1.
REQ-020 output_one_hot SHALL equal the lowest set bit of the remaining register; output_index SHALL equal its binary position.
REQ-021 output_last SHALL be 1 exactly when the remaining register has no set bit other than output_one_hot.
REQ-022 On an output handshake, the current bit SHALL be cleared from the remaining register; if output_last, the state SHALL return to IDLE.
REQ-023 Beats SHALL be emitted in strictly ascending index order, one per handshake, at most one per cycle; the beat count SHALL equal the popcount of the vector.
REQ-024 While output_valid is 1 and output_ready is 0, every output SHALL hold its value.
REQ-025 output_valid SHALL NOT depend combinationally on output_ready.
REQ-026 In IDLE, output_one_hot, output_index, and output_last SHALL be 0.
REQ-027 Accepting a new vector in the cycle after the last beat's handshake is allowed; a vector is never accepted during SCAN.

Reset
REQ-028 While reset is high, the state SHALL be IDLE, the remaining register 0, and the outputs input_ready=1, output_valid=0, busy=0, output_one_hot=0, output_index=0, output_last=0.
REQ-029 Reset asserted during SCAN SHALL abort the vector immediately, asynchronously, and discard its remaining beats.

Structure
REQ-030 The state enumeration SHALL be local to the module; no shared package is required.
REQ-031 Lowest-set-bit extraction SHALL instantiate small_first_one (WIDTH) on the remaining register; the one-hot-to-binary index conversion SHALL be internal logic.

Verification
REQ-032 Reset: assert reset, release -> input_ready=1, output_valid=0, busy=0, all data outputs 0.
REQ-033 Vector 8'b1010_0100 with output_ready held at 1 -> three consecutive beats: index 2/one-hot 8'h04, index 5/8'h20, index 7/8'h80 with last=1; then input_ready=1.
REQ-034 Vector 8'h00 -> accepted in one cycle, output_valid never asserts, input_ready stays 1.
REQ-035 Vector 8'hFF with output_ready toggling pseudo-randomly -> eight beats, indices 0..7; outputs stable during stalls; last only on index 7.
REQ-036 Vector 8'hFF, reset pulsed after two beats -> output_valid drops during reset; the next vector 8'h80 yields a single beat, index 7, last=1.
REQ-037 Exhaustive sweep of all 256 vectors with random output_ready -> beat sequence matches a model iterating set bits ascending; beat count equals popcount.
